fetch_sequencer: RTL
====================

# fetch_sequencer

Sequences the 15-word instruction memory for the processor front end. After a start pulse it walks the program counter from address 0 and drives the memory's address and read enable. Each returned word is registered into a valid/ready output stage for the decoder. Fetch stops at the first all-zero word, at the last memory address, or on an out-of-range redirect.

## Interface
- ADDR_W, 4, width of the instruction memory address and of the PC
- DEPTH, 15, number of instruction words; valid addresses are 0..DEPTH-1
- DATA_W, 32, instruction width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins fetch from address 0; ignored while busy
- imem_addr  out  ADDR_W  address to the instruction memory; equals the PC register
- imem_read_en  out  1  read enable to the instruction memory
- imem_instr  in  DATA_W  combinational read data from the memory, same cycle
- instr_out  out  DATA_W  registered instruction presented to the decoder
- pc_out  out  ADDR_W  address that instr_out was fetched from
- instr_valid  out  1  instr_out/pc_out hold a live instruction
- instr_ready  in  1  decoder accepts the instruction when valid && ready
- redirect_valid  in  1  one-cycle request to move the PC (branch or jump)
- redirect_addr  in  ADDR_W  new PC target
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a run completes
- instr_count  out  ADDR_W+1  number of accepted handshakes in the current or last run

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - imem_read_en=0 and the PC is held.
  - On start: PC<=0, instr_count<=0, go to RUN.
- RUN, fetch condition: imem_read_en = !redirect_valid && (!instr_valid || instr_ready).
- RUN, fetch of a non-zero word:
  - instr_out<=imem_instr, pc_out<=PC, instr_valid<=1, PC<=PC+1.
  - If PC==DEPTH-1, go to DRAIN after loading the word.
- RUN, fetch of a zero word:
  - The word is not loaded. instr_valid clears if the old word was accepted this cycle.
  - PC is unchanged; go to DRAIN.
- RUN, no fetch this cycle: if instr_valid && instr_ready, instr_valid<=0.
- RUN, redirect_valid=1:
  - No fetch this cycle. instr_valid<=0, which flushes any held word; a same-cycle handshake still counts.
  - If redirect_addr < DEPTH: PC<=redirect_addr and stay in RUN.
  - Otherwise go to DRAIN.
- DRAIN:
  - imem_read_en=0.
  - When instr_valid=0 or the word is accepted this cycle: instr_valid<=0, done<=1, go to IDLE.
- redirect_valid is ignored in IDLE and DRAIN. start is ignored in RUN and DRAIN.
- instr_count increments on every valid && ready cycle and saturates at 2^(ADDR_W+1)-1.
- PC arithmetic is ADDR_W bits. It never wraps, because address DEPTH-1 forces DRAIN.

## Timing
- Reset values: PC=0, imem_addr=0, imem_read_en=0, instr_out=0, pc_out=0, instr_valid=0, busy=0, done=0, instr_count=0, state=IDLE.
- A reset asserted mid-run aborts the run and returns to these values on the next edge, with no done pulse.
- Latency: start in cycle 0 → imem_read_en=1 in cycle 1 → first instr_valid in cycle 2.
- Throughput is 1 instruction per cycle while instr_ready=1.
- Backpressure: instr_out, pc_out and instr_valid hold stable while valid && !ready. The PC does not advance.
- Redirect costs one bubble cycle: the target is fetched in the cycle after redirect_valid.
- done is high for exactly one cycle, the cycle in which busy first reads 0.

## Test plan
- Program 8c0c0000, 8c0d0001, 8c0e0002, 8c0f0003, 018d4820, 01cf5020, 01494022, ac080004 at addresses 0-7, zero at address 8; ready=1; start at cycle 0:
  - instr_valid cycles 2-9 with pc_out 0-7 and the matching words.
  - Address 8 is read in cycle 9; DRAIN in cycle 10; done=1 and busy=0 in cycle 11; instr_count=8.
- Same program, instr_ready low in cycles 3-5:
  - instr_out holds 8c0d0001 (pc_out=1) through cycle 5, and imem_addr holds 2.
  - Sequence resumes unchanged; instr_count=8.
- redirect_valid=1 with redirect_addr=6 in cycle 4:
  - instr_valid=0 in cycle 5; the address 6 fetch happens in cycle 5.
  - pc_out=6 with 01494022 in cycle 6, then 7, then done; no word from addresses 3-5 appears after the flush.
- Memory full of non-zero words (addresses 0-14), ready=1:
  - 15 instructions delivered, the last with pc_out=14; then done; instr_count=15; the PC never reads 15.
- redirect_addr=15 mid-run: enters DRAIN, the held word is flushed, done the following cycle.
- Corner cases:
  - start while busy is ignored.
  - rst asserted in cycle 5 of a run → all outputs at reset values in cycle 6, no done pulse.
  - A fresh start then replays from address 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with valid/ready decoder stage
module fetch_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_read_en,
    input  logic [DATA_W-1:0] imem_instr,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   COUNT_MAX = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     count_q, count_d;

    logic                handshake;
    logic                fetch;
    logic                word_zero;
    logic                redirect_in_range;

    // The output stage can take a new word when it is empty or being emptied this cycle;
    // a redirect always steals the cycle so the target is fetched one cycle later.
    assign handshake         = valid_q && instr_ready;
    assign fetch             = (state_q == S_RUN) && !redirect_valid && (!valid_q || instr_ready);
    assign word_zero         = (imem_instr == '0);
    assign redirect_in_range = ({1'b0, redirect_addr} < DEPTH_W);

    // Next-state, PC, output-stage and counter update rules.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        count_d  = count_q;

        // Counts every accepted word, including one accepted in the redirect or drain cycle.
        if (handshake && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (redirect_valid) begin
                    // Flush the held word; a same-cycle handshake was already counted above.
                    valid_d = 1'b0;
                    if (redirect_in_range) begin
                        pc_d = redirect_addr;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (fetch) begin
                    if (!word_zero) begin
                        instr_d  = imem_instr;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        // The last address ends the program; holding the PC keeps it in range.
                        if (pc_q == LAST_ADDR) begin
                            state_d = S_DRAIN;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end else begin
                        // Terminator word is never presented to the decoder.
                        valid_d = valid_q && !handshake;
                        state_d = S_DRAIN;
                    end
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end

            S_DRAIN: begin
                if (!valid_q || instr_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign imem_read_en = fetch;
    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign instr_valid  = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign instr_count  = count_q;

endmodule
